// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: job/frame sequencer between the sample source, FFT_compute and bitrev_fifo.
// Define FFT_CTRL_PERF_EN to add the saturating busy-cycle and back-pressure stall counters.
module fft_frame_ctrl #(
  parameter int DATA_W     = 64,
  parameter int MAX_LOG2N  = 10,
  parameter int SETTLE_CYC = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cfg_point,
  input  logic [7:0]        cfg_frames,
  input  logic              start,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              comp_valid,
  output logic [DATA_W-1:0] comp_data,
  output logic [3:0]        comp_point,
  input  logic              comp_out_valid,
  input  logic              sink_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       perf_cycles,
  output logic [15:0]       perf_stalls
);

  localparam int CW = MAX_LOG2N + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1) + 1;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {IDLE, SETTLE, LOAD, DRAIN, ERR} state_t;

  state_t        state, state_next;
  logic [3:0]    point_q;
  logic [7:0]    frames_rem;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] in_cnt, out_cnt, in_next, out_next, frame_n;
  logic [TW-1:0] drain_cnt;
  logic          accept, cfg_ok, job_start, frame_end, last_frame, settle_end, timeout_hit;

  assign frame_n     = CW'(1) << point_q;
  assign cfg_ok      = (cfg_point != 4'd0) && (int'(cfg_point) <= MAX_LOG2N);
  assign job_start   = start && (state == IDLE || state == ERR);
  assign src_ready   = (state == LOAD) && sink_ready;
  assign accept      = src_ready && src_valid;
  assign in_next     = in_cnt + CW'(accept);
  assign out_next    = out_cnt + CW'(comp_out_valid);
  assign last_frame  = (frames_rem == 8'd0);
  assign timeout_hit = int'(drain_cnt) >= TIMEOUT;
  assign busy        = (state == SETTLE) || (state == LOAD) || (state == DRAIN);
  assign comp_point  = point_q;

  // Leave SETTLE one cycle early so the first registered comp_valid lands
  // exactly SETTLE_CYC cycles after comp_point changed.
  assign settle_end  = int'(settle_cnt) + 2 >= SETTLE_CYC;

  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    case (state)
      IDLE, ERR: if (start) state_next = cfg_ok ? SETTLE : ERR;
      SETTLE:    if (settle_end) state_next = LOAD;
      LOAD: begin
        if (in_next == frame_n) begin
          if (out_next >= frame_n) frame_end = 1'b1;
          else                     state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_next >= frame_n) frame_end = 1'b1;
        else if (timeout_hit)    state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
    if (frame_end) state_next = last_frame ? IDLE : LOAD;
  end

  // Output beats past N stay in out_cnt so they count toward the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      point_q    <= '0;
      frames_rem <= '0;
      settle_cnt <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      drain_cnt  <= '0;
      comp_valid <= 1'b0;
      comp_data  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      comp_valid <= accept;
      done       <= frame_end && last_frame;
      if (accept) comp_data <= src_data;
      if (job_start) begin
        err        <= !cfg_ok;
        settle_cnt <= '0;
        in_cnt     <= '0;
        out_cnt    <= '0;
        drain_cnt  <= '0;
        if (cfg_ok) begin
          point_q    <= cfg_point;
          frames_rem <= (cfg_frames == 8'd0) ? 8'd0 : cfg_frames - 8'd1;
        end
      end else if (state == DRAIN && state_next == ERR) begin
        err <= 1'b1;
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
      if (frame_end) begin
        in_cnt    <= '0;
        out_cnt   <= out_next - frame_n;
        drain_cnt <= '0;
        if (!last_frame) frames_rem <= frames_rem - 8'd1;
      end else if (state == LOAD) begin
        in_cnt    <= in_next;
        out_cnt   <= out_next;
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        out_cnt   <= out_next;
        drain_cnt <= drain_cnt + TW'(1);
      end
    end
  end

`ifdef FFT_CTRL_PERF_EN
  logic [15:0] cyc_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst || job_start) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
      if (state == LOAD && src_valid && !sink_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stalls = stall_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized bench for fft_frame_ctrl with a cycle-level job model,
// a queued sample source and a fixed-latency FFT engine stand-in.
module tb_fft_frame_ctrl;

  localparam int DATA_W     = 64;
  localparam int MAX_LOG2N  = 10;
  localparam int SETTLE_CYC = 16;
  localparam int TIMEOUT    = 4096;
  localparam int LAT        = 3;

  logic              clk = 1'b0;
  logic              rst, start, src_valid, src_ready, comp_valid, comp_out_valid;
  logic              sink_ready, busy, done, err;
  logic [3:0]        cfg_point, comp_point;
  logic [7:0]        cfg_frames;
  logic [DATA_W-1:0] src_data, comp_data;
  logic [15:0]       perf_cycles, perf_stalls;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .DATA_W(DATA_W), .MAX_LOG2N(MAX_LOG2N), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_point(cfg_point), .cfg_frames(cfg_frames), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .comp_valid(comp_valid), .comp_data(comp_data), .comp_point(comp_point),
    .comp_out_valid(comp_out_valid), .sink_ready(sink_ready), .busy(busy), .done(done),
    .err(err), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  int checkCount = 0;
  int passCount  = 0;
  int cyc = 0;

  // Job model: phase is derived from the start cycle, settle length and sample/beat counts.
  bit   mActive, mErr, mPrevAcc, mRstJust, checking;
  int   mPoint, mFrames, mFrame, mAcc, mOut, mLoadStart, mDrain, mDoneAt, mCyc, mStall;
  logic [DATA_W-1:0] mPrevData;

  logic [DATA_W-1:0] srcQ[$];
  int   beatQ[$];
  int   validPct, sinkMode, cvCount, doneCount, firstCv, jobStart, jobAcc;
  bit   silent;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
  endtask

  task automatic resetModel();
    mActive = 0; mErr = 0; mPrevAcc = 0; mPoint = 0; mFrames = 1; mFrame = 0;
    mAcc = 0; mOut = 0; mLoadStart = 0; mDrain = 0; mDoneAt = -1; mCyc = 0; mStall = 0;
    mPrevData = '0; mRstJust = 1;
    srcQ.delete(); beatQ.delete();
  endtask

  // One clock: drive inputs just after negedge, check outputs, advance the model.
  task automatic stepCycle(input bit doStart, input logic [3:0] p, input logic [7:0] f, input bit doReset);
    bit inLoad, acc, drainPhase;
    int n;
    rst = doReset; start = doStart; cfg_point = p; cfg_frames = f;
    case (sinkMode)
      0:       sink_ready = 1'b1;
      1:       sink_ready = (cyc % 10) < 5;
      default: sink_ready = $urandom_range(99) < 75;
    endcase
    src_valid = (srcQ.size() > 0) && ($urandom_range(99) < validPct);
    src_data  = src_valid ? srcQ[0] : {$urandom, $urandom};
    comp_out_valid = !silent && (beatQ.size() > 0) && (beatQ[0] == cyc);
    #1;
    n = 1 << mPoint;
    inLoad = mActive && (cyc >= mLoadStart) && (mAcc < n);
    if (checking) begin
      checkOutput("busy", busy, mActive);
      checkOutput("err", err, mErr);
      checkOutput("done", done, cyc == mDoneAt);
      checkOutput("comp_point", comp_point, mPoint);
      checkOutput("comp_valid", comp_valid, mPrevAcc);
      checkOutput("src_ready", src_ready, inLoad && sink_ready);
      if (mPrevAcc && comp_valid) checkOutput("comp_data", comp_data, mPrevData);
      if (mRstJust) checkOutput("comp_data_rst", comp_data, 0);
`ifdef FFT_CTRL_PERF_EN
      checkOutput("perf_cycles", perf_cycles, mCyc);
      checkOutput("perf_stalls", perf_stalls, mStall);
`else
      checkOutput("perf_cycles", perf_cycles, 0);
      checkOutput("perf_stalls", perf_stalls, 0);
`endif
    end
    mRstJust = 0;
    if (comp_valid) begin
      cvCount++;
      if (firstCv < 0) firstCv = cyc;
      if (!silent) beatQ.push_back(cyc + LAT);
    end
    if (done) doneCount++;
    if (comp_out_valid) void'(beatQ.pop_front());
    if (doReset) begin
      resetModel();
    end else begin
      acc = inLoad && src_valid && sink_ready;
      drainPhase = mActive && (cyc >= mLoadStart) && (mAcc == n);
      if (inLoad && src_valid && !sink_ready && mStall < 65535) mStall++;
      if (mActive && mCyc < 65535) mCyc++;
      mPrevAcc = acc;
      if (acc) begin
        mPrevData = srcQ.pop_front();
        mAcc++;
        jobAcc++;
      end
      if (mActive && cyc >= mLoadStart && comp_out_valid) mOut++;
      if (mActive && mAcc == n && mOut >= n) begin
        mOut -= n; mAcc = 0; mDrain = 0; mFrame++;
        if (mFrame == mFrames) begin
          mActive = 0;
          mDoneAt = cyc + 1;
        end
      end else if (drainPhase) begin
        mDrain++;
        if (mDrain > TIMEOUT) begin
          mActive = 0;
          mErr = 1;
        end
      end
      if (doStart && !mActive) begin
        mCyc = 0; mStall = 0;
        mErr = !(p >= 1 && p <= MAX_LOG2N);
        if (!mErr) begin
          mActive = 1; mPoint = p; mFrames = (f == 0) ? 1 : f; mFrame = 0;
          mAcc = 0; mOut = 0; mDrain = 0; mDoneAt = -1;
          mLoadStart = cyc + SETTLE_CYC;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic [7:0] f, input int vp, input int mode,
                               input bit sil, input bit seqData, input int abortAt, input int restartAt,
                               input int expBeats, input int expDone);
    int total, budget;
    bit restarted;
    total = (1 << p) * ((f == 0) ? 1 : f);
    srcQ.delete(); beatQ.delete();
    for (int i = 0; i < total; i++) srcQ.push_back(seqData ? 64'(i + 1) : {$urandom, $urandom});
    validPct = vp; sinkMode = mode; silent = sil;
    cvCount = 0; doneCount = 0; firstCv = -1; jobAcc = 0; jobStart = cyc;
    budget = 0; restarted = 0;
    stepCycle(1'b1, p, f, 1'b0);
    while ((mActive || cyc <= mDoneAt) && budget < 6000) begin
      if (abortAt >= 0 && jobAcc == abortAt) begin
        stepCycle(1'b0, p, f, 1'b1);
      end else if (restartAt >= 0 && !restarted && jobAcc == restartAt) begin
        stepCycle(1'b1, 4'd3, 8'd7, 1'b0);
        restarted = 1;
      end else begin
        stepCycle(1'b0, p, f, 1'b0);
      end
      budget++;
    end
    if (budget >= 6000) checkOutput("cycle_budget", 0, 1);
    stepCycle(1'b0, p, f, 1'b0);
    checkOutput("beats", cvCount, expBeats);
    checkOutput("done_pulses", doneCount, expDone);
  endtask

  task automatic startOnly(input logic [3:0] p, input logic [7:0] f);
    cvCount = 0;
    stepCycle(1'b1, p, f, 1'b0);
    repeat (4) stepCycle(1'b0, p, f, 1'b0);
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_beats", cvCount, 0);
  endtask

  initial begin
    rst = 1; start = 0; cfg_point = 0; cfg_frames = 0; src_valid = 0; src_data = '0;
    sink_ready = 1; comp_out_valid = 0; validPct = 100; sinkMode = 0; silent = 0;
    resetModel();
    checking = 0;
    @(negedge clk);
    stepCycle(1'b0, 4'd0, 8'd0, 1'b1);
    stepCycle(1'b0, 4'd0, 8'd0, 1'b1);
    checking = 1;
    repeat (2) stepCycle(1'b0, 4'd0, 8'd0, 1'b0);

    applyStimulus(4'd6, 8'd1, 100, 0, 0, 1, -1, -1, 64, 1);
    checkOutput("first_valid_latency", firstCv - jobStart - 1, SETTLE_CYC);
    applyStimulus(4'd6, 8'd1, 100, 1, 0, 1, -1, -1, 64, 1);
    applyStimulus(4'd4, 8'd3, 70, 2, 0, 0, -1, -1, 48, 1);
    applyStimulus(4'd4, 8'd0, 80, 2, 0, 0, -1, -1, 16, 1);

    startOnly(4'd0, 8'd1);
    startOnly(4'd11, 8'd1);

    applyStimulus(4'd3, 8'd1, 100, 0, 1, 0, -1, -1, 8, 0);
    checkOutput("err_after_timeout", err, 1);
    applyStimulus(4'd2, 8'd2, 100, 2, 0, 0, -1, -1, 8, 1);
    checkOutput("err_cleared", err, 0);

    applyStimulus(4'd6, 8'd1, 100, 0, 0, 1, 20, -1, 20, 0);
    applyStimulus(4'd6, 8'd1, 90, 2, 0, 0, -1, -1, 64, 1);

    applyStimulus(4'd5, 8'd2, 100, 0, 0, 0, -1, 10, 64, 1);
    checkOutput("point_after_busy_start", comp_point, 5);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
